// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - state encodings, opcodes and datapath select codes
// Shared with ALU control so select encodings stay in one place.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_ADDIEX = 4'd8,
    ST_ADDIWB = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS main control Moore FSM
// Outputs decode state only, except FETCH commit gating on MemReady and IllegalOp in DECODE.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp
);

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = MemReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (Op == OP_LW)      state_d = ST_MEMRD;
        else if (Op == OP_SW) state_d = ST_MEMWR;
        else                  state_d = ST_FETCH;
      end
      ST_MEMRD:  state_d = MemReady ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = MemReady ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_RWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Everything held at zero while rst is high so no partial write escapes mid-instruction.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    IllegalOp   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          MemRead  = 1'b1;
          IRWrite  = MemReady;
          PCWrite  = MemReady;
          ALUSrcB  = SRCB_FOUR;
          ALUOp    = ALUOP_ADD;
          PCSource = PCSRC_ALU;
        end
        ST_DECODE: begin
          ALUSrcB   = SRCB_IMM_SH2;
          ALUOp     = ALUOP_ADD;
          IllegalOp = !op_supported(Op);
        end
        ST_MEMADR, ST_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ADD;
        end
        ST_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        ST_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        ST_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        ST_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_REG;
          ALUOp   = ALUOP_FUNCT;
        end
        ST_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        ST_ADDIWB: RegWrite = 1'b1;
        ST_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = SRCB_REG;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        ST_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
// Stimulus queues expected output vectors; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSource;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,IllegalOp}
  localparam logic [16:0] E_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_FWAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] E_DECILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] E_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] E_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] E_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] E_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] E_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

  logic [16:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad = 0;

  wire [16:0] act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, IllegalOp};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", n, act, e);
      end
      total++;
      if ((PCWrite & PCWriteCond) | (MemRead & MemWrite)) begin
        bad++;
        $display("FAIL %s exclusive: got PCW=%b PCWC=%b MR=%b MW=%b want no overlap",
                 n, PCWrite, PCWriteCond, MemRead, MemWrite);
      end
    end
  end

  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [16:0] e, input string n);
    rst = r;
    Op = op;
    MemReady = mr;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    Op = 6'h00;
    MemReady = 1'b0;
    @(posedge clk);
    #1;
    step(1, 6'h00, 1, E_ZERO,   "reset_hold");
    // R-type, ready memory: FETCH DECODE EXEC RWB then FETCH on cycle 5
    step(0, 6'h00, 1, E_FETCH,  "r_fetch");
    step(0, 6'h00, 1, E_DECODE, "r_decode");
    step(0, 6'h3F, 1, E_EXEC,   "r_exec_op_ignored");
    step(0, 6'h3F, 1, E_RWB,    "r_rwb");
    // fetch stall 2 cycles then one commit
    step(0, 6'h23, 0, E_FWAIT,  "fetch_wait1");
    step(0, 6'h23, 0, E_FWAIT,  "fetch_wait2");
    step(0, 6'h23, 1, E_FETCH,  "lw_fetch");
    step(0, 6'h23, 1, E_DECODE, "lw_decode");
    step(0, 6'h23, 1, E_MEMADR, "lw_memadr");
    step(0, 6'h23, 0, E_MEMRD,  "lw_memrd_w1");
    step(0, 6'h23, 0, E_MEMRD,  "lw_memrd_w2");
    step(0, 6'h23, 0, E_MEMRD,  "lw_memrd_w3");
    step(0, 6'h23, 1, E_MEMRD,  "lw_memrd_go");
    step(0, 6'h23, 1, E_MEMWB,  "lw_memwb");
    // sw
    step(0, 6'h2B, 1, E_FETCH,  "sw_fetch");
    step(0, 6'h2B, 1, E_DECODE, "sw_decode");
    step(0, 6'h2B, 1, E_MEMADR, "sw_memadr");
    step(0, 6'h2B, 1, E_MEMWR,  "sw_memwr");
    // addi
    step(0, 6'h08, 1, E_FETCH,  "addi_fetch");
    step(0, 6'h08, 1, E_DECODE, "addi_decode");
    step(0, 6'h08, 1, E_MEMADR, "addi_ex");
    step(0, 6'h08, 1, E_ADDIWB, "addi_wb");
    // beq then j
    step(0, 6'h04, 1, E_FETCH,  "beq_fetch");
    step(0, 6'h04, 1, E_DECODE, "beq_decode");
    step(0, 6'h04, 1, E_BRANCH, "beq_branch");
    step(0, 6'h02, 1, E_FETCH,  "j_fetch");
    step(0, 6'h02, 1, E_DECODE, "j_decode");
    step(0, 6'h02, 1, E_JUMP,   "j_jump");
    // illegal opcode
    step(0, 6'h3F, 1, E_FETCH,  "ill_fetch");
    step(0, 6'h3F, 1, E_DECILL, "ill_decode");
    step(0, 6'h3F, 1, E_FETCH,  "ill_back_fetch");
    step(0, 6'h00, 1, E_DECODE, "ill_next_decode");
    step(0, 6'h00, 1, E_EXEC,   "ill_next_exec");
    step(0, 6'h00, 1, E_RWB,    "ill_next_rwb");
    // reset asserted mid-MEMRD
    step(0, 6'h23, 1, E_FETCH,  "rst_fetch");
    step(0, 6'h23, 1, E_DECODE, "rst_decode");
    step(0, 6'h23, 1, E_MEMADR, "rst_memadr");
    step(0, 6'h23, 0, E_MEMRD,  "rst_memrd");
    step(1, 6'h23, 1, E_ZERO,   "rst_mid_memrd");
    step(0, 6'h23, 0, E_FWAIT,  "rst_release_fetch");
    step(0, 6'h23, 1, E_FETCH,  "rst_release_commit");
    step(0, 6'h23, 1, E_DECODE, "rst_release_decode");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
